// File: rtl/ascii_token_parser.sv
// ascii_token_parser
//   Turns a stream of received UART bytes into calculator tokens. Consecutive
//   decimal digits accumulate into one unsigned operand. Command letters
//   decode to operation codes. Each completed number or command is emitted
//   as a one-cycle token strobe. Malformed input raises a one-cycle error
//   strobe.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   rx_valid       one-cycle strobe, rx_data holds a received byte
//   rx_data[7:0]   received ASCII byte
//   rx_ready       a byte can be accepted this cycle (low only in EMIT_OP)
//   tok_valid      one-cycle token strobe
//   tok_is_number  1 = numeric token, 0 = command token
//   tok_value      operand value (0 for command tokens)
//   tok_op[3:0]    12 SIN, 13 COS, 14 SQUARE, 15 IS_PRIME (0 for numbers)
//   err_valid      one-cycle error strobe
//   err_code[1:0]  1 overflow, 2 invalid character; held until next error
//   busy           a number is partially accumulated (ACCUM or SKIP)
module ascii_token_parser #(
  parameter int NUM_WIDTH  = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 tok_valid,
  output logic                 tok_is_number,
  output logic [NUM_WIDTH-1:0] tok_value,
  output logic [3:0]           tok_op,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  // Four spare bits hold acc*10 + digit without wrapping.
  localparam int AW = NUM_WIDTH + 4;
  localparam logic [AW-1:0] MAX_VAL = {4'b0000, {NUM_WIDTH{1'b1}}};
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_INV = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_SKIP    = 2'd2,
    S_EMIT_OP = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             op_q, op_d;
  logic                   tok_valid_q, tok_valid_d;
  logic                   tok_is_number_q, tok_is_number_d;
  logic [NUM_WIDTH-1:0]   tok_value_q, tok_value_d;
  logic [3:0]             tok_op_q, tok_op_d;
  logic                   err_valid_q, err_valid_d;
  logic [1:0]             err_code_q, err_code_d;

  // Byte classification
  logic       is_digit, is_cmd, is_term, is_esc;
  logic [3:0] cmd_op;

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A) || (rx_data == 8'h20);
    is_esc   = (rx_data == 8'h1B);
    is_cmd   = 1'b1;
    cmd_op   = 4'd0;
    case (rx_data)
      8'h73, 8'h53: cmd_op = 4'd12;
      8'h63, 8'h43: cmd_op = 4'd13;
      8'h6B, 8'h4B: cmd_op = 4'd14;
      8'h70, 8'h50: cmd_op = 4'd15;
      default:      is_cmd = 1'b0;
    endcase
  end

  logic          accept;
  logic [AW-1:0] acc_ext, next_val;
  logic          ovf;

  assign accept   = rx_valid && (state_q != S_EMIT_OP);
  assign acc_ext  = AW'(acc_q);
  assign next_val = (acc_ext << 3) + (acc_ext << 1) + AW'(rx_data[3:0]);
  // Too many digits (leading zeros included) or value out of range.
  assign ovf      = (cnt_q == MAX_CNT) || (next_val > MAX_VAL);

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    tok_valid_d     = 1'b0;
    tok_is_number_d = 1'b0;
    tok_value_d     = '0;
    tok_op_d        = 4'd0;
    err_valid_d     = 1'b0;
    err_code_d      = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_d   = NUM_WIDTH'(rx_data[3:0]);
            cnt_d   = CW'(1);
            state_d = S_ACCUM;
          end else if (is_cmd) begin
            tok_valid_d = 1'b1;
            tok_op_d    = cmd_op;
          end else if (!is_term && !is_esc) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_INV;
          end
        end
      end

      S_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (ovf) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_OVF;
              acc_d       = '0;
              cnt_d       = '0;
              state_d     = S_SKIP;
            end else begin
              acc_d = next_val[NUM_WIDTH-1:0];
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // Any non-digit closes the operand; only term/cmd emit it.
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
            if (is_term || is_cmd) begin
              tok_valid_d     = 1'b1;
              tok_is_number_d = 1'b1;
              tok_value_d     = acc_q;
            end
            if (is_cmd) begin
              op_d    = cmd_op;
              state_d = S_EMIT_OP;
            end else if (!is_term && !is_esc) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_INV;
            end
          end
        end
      end

      S_SKIP: begin
        if (accept && !is_digit) begin
          state_d = S_IDLE;
          if (is_cmd) begin
            tok_valid_d = 1'b1;
            tok_op_d    = cmd_op;
          end else if (!is_term && !is_esc) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_INV;
          end
        end
      end

      S_EMIT_OP: begin
        // The number token went out last cycle; now the latched command.
        tok_valid_d = 1'b1;
        tok_op_d    = op_q;
        op_d        = 4'd0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      acc_q           <= '0;
      cnt_q           <= '0;
      op_q            <= 4'd0;
      tok_valid_q     <= 1'b0;
      tok_is_number_q <= 1'b0;
      tok_value_q     <= '0;
      tok_op_q        <= 4'd0;
      err_valid_q     <= 1'b0;
      err_code_q      <= 2'd0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      tok_valid_q     <= tok_valid_d;
      tok_is_number_q <= tok_is_number_d;
      tok_value_q     <= tok_value_d;
      tok_op_q        <= tok_op_d;
      err_valid_q     <= err_valid_d;
      err_code_q      <= err_code_d;
    end
  end

  assign rx_ready      = (state_q != S_EMIT_OP);
  assign busy          = (state_q == S_ACCUM) || (state_q == S_SKIP);
  assign tok_valid     = tok_valid_q;
  assign tok_is_number = tok_is_number_q;
  assign tok_value     = tok_value_q;
  assign tok_op        = tok_op_q;
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_ascii_token_parser.sv
module tb_ascii_token_parser;

  localparam int NW = 16;
  localparam int MD = 5;
  localparam int VW = NW + 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          tok_valid;
  logic          tok_is_number;
  logic [NW-1:0] tok_value;
  logic [3:0]    tok_op;
  logic          err_valid;
  logic [1:0]    err_code;
  logic          busy;

  int errors = 0;
  int checks = 0;

  ascii_token_parser #(.NUM_WIDTH(NW), .MAX_DIGITS(MD)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tok_valid     (tok_valid),
    .tok_is_number (tok_is_number),
    .tok_value     (tok_value),
    .tok_op        (tok_op),
    .err_valid     (err_valid),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model: the operand is kept as a plain integer plus a digit
  // count; "skipping" marks the tail of an overflowed number; pend_op holds
  // a command still owed after its preceding number token.
  bit m_have, m_skip;
  int m_num, m_ndig, m_pend;
  // Expected DUT outputs as of now.
  bit e_tv, e_isn, e_ev, e_busy, e_rdy;
  int e_val, e_op, e_ec;

  function automatic int cmd_code(input logic [7:0] b);
    case (b)
      8'h73, 8'h53: return 12;
      8'h63, 8'h43: return 13;
      8'h6B, 8'h4B: return 14;
      8'h70, 8'h50: return 15;
      default:      return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_have = 0; m_skip = 0; m_num = 0; m_ndig = 0; m_pend = -1;
    e_tv = 0; e_isn = 0; e_val = 0; e_op = 0; e_ev = 0; e_ec = 0;
    e_busy = 0; e_rdy = 1;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    int op;
    int nv;
    e_tv = 0; e_isn = 0; e_val = 0; e_op = 0; e_ev = 0;
    op = cmd_code(b);
    if (m_pend >= 0) begin
      // Parser is not ready: any byte offered now is lost.
      e_tv = 1; e_op = m_pend; m_pend = -1;
    end else if (v) begin
      if (b >= 8'h30 && b <= 8'h39) begin
        if (m_skip) begin
          // discarded
        end else if (m_have) begin
          nv = m_num * 10 + int'(b - 8'h30);
          if (m_ndig == MD || nv > (2 ** NW) - 1) begin
            e_ev = 1; e_ec = 1; m_have = 0; m_skip = 1;
          end else begin
            m_num = nv; m_ndig++;
          end
        end else begin
          m_have = 1; m_num = int'(b - 8'h30); m_ndig = 1;
        end
      end else if (op != 0) begin
        if (m_have) begin
          e_tv = 1; e_isn = 1; e_val = m_num; m_pend = op;
        end else begin
          e_tv = 1; e_op = op;
        end
        m_have = 0; m_skip = 0;
      end else if (b == 8'h0D || b == 8'h0A || b == 8'h20) begin
        if (m_have) begin
          e_tv = 1; e_isn = 1; e_val = m_num;
        end
        m_have = 0; m_skip = 0;
      end else if (b == 8'h1B) begin
        m_have = 0; m_skip = 0;
      end else begin
        e_ev = 1; e_ec = 2; m_have = 0; m_skip = 0;
      end
    end
    e_busy = m_have || m_skip;
    e_rdy  = (m_pend < 0);
  endtask

  task automatic check(input string tag);
    logic [VW-1:0] obs, exp;
    logic [31:0]   val32, op32, ec32;
    val32 = e_val; op32 = e_op; ec32 = e_ec;
    obs = {tok_valid, tok_is_number, tok_value, tok_op, err_valid, err_code, busy, rx_ready};
    exp = {e_tv, e_isn, val32[NW-1:0], op32[3:0], e_ev, ec32[1:0], e_busy, e_rdy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (tv,isnum,value,op,ev,ec,busy,ready)", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b, input string tag);
    rx_valid = v;
    rx_data  = b;
    model_step(v, b);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check(tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    bit v;
    string cmds;
    cmds     = "sScCkKpP";
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    #12;
    check("reset_state");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset");

    // Basic number
    send_str("123", "num123_digits");
    step(1, 8'h0D, "num123_token");
    step(0, 8'h00, "num123_after");

    // Number followed by command, byte dropped while not ready
    send_str("42s", "num42_cmd");
    step(1, "9", "dropped_byte_op_token");
    step(0, 8'h00, "num42_after");

    // Max value, then overflow by digit count, then overflow by value
    send_str("65535", "max_digits");
    step(1, 8'h0D, "max_token");
    send_str("655357", "ovf_count");
    send_str("12", "skip_digits");
    step(1, "P", "skip_cmd");
    send_str("65536", "ovf_value");
    step(1, 8'h0D, "ovf_value_term");

    // Leading zeros count as digits
    send_str("000001", "ovf_leading_zero");
    step(1, 8'h20, "ovf_space");
    send_str("00012", "lead_zero_ok");
    step(1, 8'h0A, "lead_zero_token");

    // Invalid character, command in idle, escape
    send_str("7#", "invalid_in_accum");
    step(1, "K", "cmd_idle_k");
    step(1, "#", "invalid_in_idle");
    step(1, 8'h0D, "term_in_idle");
    step(1, "9", "esc_seq_digit");
    step(1, 8'h1B, "esc_seq_esc");
    step(1, 8'h0D, "esc_seq_term");

    // Reset while accumulating
    send_str("12", "pre_reset_accum");
    do_reset("reset_mid_accum");
    step(1, 8'h0D, "term_after_reset");

    // Reset during the not-ready cycle
    send_str("5c", "pre_reset_emit");
    do_reset("reset_mid_emit");
    step(0, 8'h00, "no_op_after_reset");
    step(1, "c", "cmd_after_reset");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < 85);
      if (r < 50)      b = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 62) b = cmds[$urandom_range(0, 7)];
      else if (r < 72) begin
        r = $urandom_range(0, 2);
        b = (r == 0) ? 8'h0D : (r == 1) ? 8'h0A : 8'h20;
      end
      else if (r < 76) b = 8'h1B;
      else             b = 8'($urandom_range(0, 255));
      step(v, b, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
